// File: rtl/pc_control_unit_pkg.sv
// Shared encodings for the PC control unit: jump/branch select codes and PC step.
package pc_control_unit_pkg;

    // Jump select encodings (reserved code behaves as a plain J)
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_J    = 2'b01;
    localparam logic [1:0] JUMP_JAL  = 2'b10;
    localparam logic [1:0] JUMP_RSVD = 2'b11;

    // Branch select encodings (reserved code is never taken)
    localparam logic [2:0] BRANCH_NONE = 3'b000;
    localparam logic [2:0] BRANCH_BEQ  = 3'b001;
    localparam logic [2:0] BRANCH_BNE  = 3'b010;
    localparam logic [2:0] BRANCH_BLTZ = 3'b011;
    localparam logic [2:0] BRANCH_BGEZ = 3'b100;
    localparam logic [2:0] BRANCH_BLEZ = 3'b101;
    localparam logic [2:0] BRANCH_BGTZ = 3'b110;
    localparam logic [2:0] BRANCH_RSVD = 3'b111;

    // Sequential instruction step in bytes
    localparam logic [31:0] PC_INCREMENT = 32'd4;

endpackage

// File: rtl/pc_control_unit_if.sv
// Bundle of the PC control unit's datapath inputs and its next-PC/status outputs.
interface pc_control_unit_if;

    logic [31:0] pc;
    logic [25:0] address;
    logic [1:0]  jump;
    logic [2:0]  branch;
    logic        jr;
    logic        zero;
    logic [31:0] sign_extend_immediate;
    logic [31:0] rs_data;
    logic [31:0] next_pc;
    logic        taken;
    logic        misalign_err;
    logic [31:0] redirect_count;

    // Decode/datapath side: supplies the instruction context, observes the result
    modport master (
        output pc, address, jump, branch, jr, zero, sign_extend_immediate, rs_data,
        input  next_pc, taken, misalign_err, redirect_count
    );

    // The PC control unit itself
    modport slave (
        input  pc, address, jump, branch, jr, zero, sign_extend_immediate, rs_data,
        output next_pc, taken, misalign_err, redirect_count
    );

endinterface

// File: rtl/pc_control_unit.sv
// Next-PC selection (jr > jump > taken branch > pc+4) with registered status:
// a sticky misaligned-jr flag and a count of redirecting cycles.
module pc_control_unit
    import pc_control_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_b,
    pc_control_unit_if.slave bus
);

    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        branch_cond;
    logic        jr_misaligned;
    logic [31:0] redirect_count_reg;
    logic        misalign_err_reg;

    // Evaluates whether the selected branch condition holds.
    function automatic logic branch_taken(
        input logic [2:0]  sel,
        input logic        zero_in,
        input logic [31:0] rs_in
    );
        logic neg;
        logic is_zero;
        logic result;
        neg     = rs_in[31];
        is_zero = (rs_in == 32'd0);
        case (sel)
            BRANCH_BEQ:  result = zero_in;
            BRANCH_BNE:  result = !zero_in;
            BRANCH_BLTZ: result = neg;
            BRANCH_BGEZ: result = !neg;
            BRANCH_BLEZ: result = neg || is_zero;
            BRANCH_BGTZ: result = !neg && !is_zero;
            default:     result = 1'b0;
        endcase
        return result;
    endfunction

    // Candidate targets; all arithmetic wraps modulo 2^32.
    always_comb begin
        pc_plus4      = bus.pc + PC_INCREMENT;
        jump_target   = {pc_plus4[31:28], bus.address, 2'b00};
        branch_target = pc_plus4 + {bus.sign_extend_immediate[29:0], 2'b00};
        branch_cond   = branch_taken(bus.branch, bus.zero, bus.rs_data);
        jr_misaligned = bus.jr && (bus.rs_data[1:0] != 2'b00);
    end

    // Fixed-priority next-PC mux; taken flags any redirect even to pc+4.
    always_comb begin
        bus.next_pc = pc_plus4;
        bus.taken   = 1'b0;
        if (bus.jr) begin
            bus.next_pc = bus.rs_data;
            bus.taken   = 1'b1;
        end else if (bus.jump != JUMP_NONE) begin
            bus.next_pc = jump_target;
            bus.taken   = 1'b1;
        end else if (branch_cond) begin
            bus.next_pc = branch_target;
            bus.taken   = 1'b1;
        end
    end

    // Status registers: sticky misalignment flag and wrapping redirect counter.
    // Jump and branch targets are word aligned by construction, so only jr can misalign.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            misalign_err_reg   <= 1'b0;
            redirect_count_reg <= 32'd0;
        end else begin
            if (jr_misaligned)
                misalign_err_reg <= 1'b1;
            if (bus.taken)
                redirect_count_reg <= redirect_count_reg + 32'd1;
        end
    end

    // Drive registered status onto the bus.
    always_comb begin
        bus.misalign_err   = misalign_err_reg;
        bus.redirect_count = redirect_count_reg;
    end

endmodule

// File: tb/tb_pc_control_unit.sv
// Self-checking bench: directed corner cases plus randomized vectors against a
// behavioural next-PC/status model.
module tb_pc_control_unit;

    logic clk;
    logic rst_b;
    pc_control_unit_if bus ();

    pc_control_unit dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference state for the registered outputs
    bit [31:0] exp_count;
    bit        exp_misalign;

    // Counts one comparison and reports it when observed differs from expected.
    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Behavioural next-PC: signed comparisons on rs, multiply-by-4 offset.
    function automatic void model(
        input  bit [31:0] pc, input bit [25:0] addr, input bit [1:0] jmp,
        input  bit [2:0] br, input bit jr, input bit zero,
        input  bit [31:0] imm, input bit [31:0] rs,
        output bit [31:0] npc, output bit tk
    );
        bit [31:0] p4;
        bit cond;
        int signed rsv;
        p4  = pc + 32'd4;
        rsv = $signed(rs);
        case (br)
            3'd1: cond = zero;
            3'd2: cond = !zero;
            3'd3: cond = rsv < 0;
            3'd4: cond = rsv >= 0;
            3'd5: cond = rsv <= 0;
            3'd6: cond = rsv > 0;
            default: cond = 1'b0;
        endcase
        tk = 1'b1;
        if (jr)             npc = rs;
        else if (jmp != 0)  npc = (p4 & 32'hF000_0000) | ({6'd0, addr} * 32'd4);
        else if (cond)      npc = p4 + imm * 32'd4;
        else begin          npc = p4; tk = 1'b0; end
    endfunction

    task automatic set_idle();
        bus.jump   = 2'b00;
        bus.branch = 3'b000;
        bus.jr     = 1'b0;
    endtask

    // Drives one vector at the falling edge, checks combinational outputs,
    // then checks the status registers just after the next rising edge.
    task automatic apply(
        input string tag, input bit [31:0] pc, input bit [25:0] addr, input bit [1:0] jmp,
        input bit [2:0] br, input bit jr, input bit zero, input bit [31:0] imm, input bit [31:0] rs
    );
        bit [31:0] npc;
        bit tk;
        @(negedge clk);
        bus.pc = pc; bus.address = addr; bus.jump = jmp; bus.branch = br;
        bus.jr = jr; bus.zero = zero; bus.sign_extend_immediate = imm; bus.rs_data = rs;
        model(pc, addr, jmp, br, jr, zero, imm, rs, npc, tk);
        #1;
        check_val({tag, ".next_pc"}, bus.next_pc, npc);
        check_val({tag, ".taken"}, {31'd0, bus.taken}, {31'd0, tk});
        @(posedge clk);
        if (tk) exp_count = exp_count + 32'd1;
        if (jr && rs[1:0] != 2'b00) exp_misalign = 1'b1;
        #1;
        check_val({tag, ".misalign_err"}, {31'd0, bus.misalign_err}, {31'd0, exp_misalign});
        check_val({tag, ".redirect_count"}, bus.redirect_count, exp_count);
        $display("vec %-12s pc=%08h jr=%0d jmp=%0d br=%0d -> next_pc=%08h taken=%0d cnt=%0d err=%0d",
                 tag, pc, jr, jmp, br, bus.next_pc, bus.taken, bus.redirect_count, bus.misalign_err);
    endtask

    // Pulses reset at a falling edge with idle inputs so no stray redirect is counted.
    task automatic do_reset(input string tag);
        @(negedge clk);
        set_idle();
        rst_b = 1'b0;
        #1;
        exp_count    = 32'd0;
        exp_misalign = 1'b0;
        check_val({tag, ".rst_count"}, bus.redirect_count, exp_count);
        check_val({tag, ".rst_err"}, {31'd0, bus.misalign_err}, {31'd0, exp_misalign});
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b = 1'b0;
        bus.pc = 32'h0; bus.address = 26'h0; bus.zero = 1'b0;
        bus.sign_extend_immediate = 32'h0; bus.rs_data = 32'h0;
        set_idle();
        exp_count = 0; exp_misalign = 0;
        #2;
        check_val("init.count", bus.redirect_count, 32'd0);
        check_val("init.err", {31'd0, bus.misalign_err}, 32'd0);
        // Combinational path is live during reset
        check_val("init.next_pc", bus.next_pc, 32'h0000_0004);
        @(negedge clk);
        rst_b = 1'b1;

        // Directed corner cases
        apply("seq",       32'h0040_0000, 26'h0, 2'b00, 3'b000, 0, 0, 32'h0, 32'h0);
        check_val("seq.abs", bus.next_pc, 32'h0040_0004);
        apply("beq_back",  32'h0040_0010, 26'h0, 2'b00, 3'b001, 0, 1, 32'hFFFF_FFFE, 32'h0);
        check_val("beq_back.abs", bus.next_pc, 32'h0040_000C);
        apply("beq_nt",    32'h0040_0010, 26'h0, 2'b00, 3'b001, 0, 0, 32'hFFFF_FFFE, 32'h0);
        check_val("beq_nt.abs", bus.next_pc, 32'h0040_0014);
        apply("j",         32'h1000_0000, 26'h40, 2'b01, 3'b000, 0, 0, 32'h0, 32'h0);
        check_val("j.abs", bus.next_pc, 32'h1000_0100);
        apply("jr_prio",   32'h0040_0000, 26'h40, 2'b01, 3'b001, 1, 1, 32'h4, 32'h0000_1234);
        check_val("jr_prio.abs", bus.next_pc, 32'h0000_1234);
        apply("jr_misal",  32'h0040_0000, 26'h40, 2'b01, 3'b001, 1, 1, 32'h4, 32'h0000_1236);
        check_val("jr_misal.err", {31'd0, bus.misalign_err}, 32'd1);
        apply("blez_zero", 32'h0040_0000, 26'h0, 2'b00, 3'b101, 0, 0, 32'h8, 32'h0);
        apply("bgtz_zero", 32'h0040_0000, 26'h0, 2'b00, 3'b110, 0, 0, 32'h8, 32'h0);
        apply("rsvd_br",   32'h0040_0000, 26'h0, 2'b00, 3'b111, 0, 1, 32'h8, 32'h0);
        apply("rsvd_jmp",  32'h2000_0000, 26'h3FF_FFFF, 2'b11, 3'b000, 0, 0, 32'h0, 32'h0);
        apply("br_to_p4",  32'h0040_0000, 26'h0, 2'b00, 3'b001, 0, 1, 32'h0, 32'h0);
        apply("wrap",      32'hFFFF_FFFC, 26'h0, 2'b00, 3'b000, 0, 0, 32'h0, 32'h0);
        check_val("wrap.abs", bus.next_pc, 32'h0000_0000);

        // Counter: three redirects from a fresh reset, then a mid-cycle reset
        do_reset("cnt");
        apply("cnt1", 32'h0000_1000, 26'h10, 2'b01, 3'b000, 0, 0, 32'h0, 32'h0);
        apply("cnt2", 32'h0000_1000, 26'h0, 2'b00, 3'b010, 0, 0, 32'h3, 32'h0);
        apply("cnt3", 32'h0000_1000, 26'h0, 2'b00, 3'b000, 1, 0, 32'h0, 32'h0000_0803);
        check_val("cnt3.abs", bus.redirect_count, 32'd3);
        #2;
        rst_b = 1'b0;
        #1;
        exp_count = 0; exp_misalign = 0;
        check_val("midrst.count", bus.redirect_count, 32'd0);
        check_val("midrst.err", {31'd0, bus.misalign_err}, 32'd0);
        check_val("midrst.next_pc", bus.next_pc, 32'h0000_0803);
        check_val("midrst.taken", {31'd0, bus.taken}, 32'd1);
        @(negedge clk);
        set_idle();
        rst_b = 1'b1;

        // Randomized vectors with periodic resets so the sticky flag stays observable
        for (int i = 0; i < 400; i++) begin
            bit [31:0] rpc, rimm, rrs;
            bit [1:0]  rjmp;
            bit        rjr;
            if (i % 50 == 49) do_reset("rnd");
            rpc  = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFFC;
            rimm = ($urandom_range(0, 1) == 1) ? 32'hFFFF_0000 | $urandom_range(0, 16'hFFFF)
                                               : 32'(unsigned'($urandom_range(0, 16'hFFFF)));
            case ($urandom_range(0, 3))
                0:       rrs = 32'h0;
                1:       rrs = $urandom & 32'hFFFF_FFFC;
                default: rrs = $urandom;
            endcase
            rjr  = ($urandom_range(0, 9) == 0);
            rjmp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            apply("rnd", rpc, 26'($urandom), rjmp, 3'($urandom_range(0, 7)), rjr,
                  1'($urandom_range(0, 1)), rimm, rrs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
